// File: rtl/ram_pkg.sv
// Shared types and default sizing for the ram_ctrl block and its storage array.
package ram_pkg;

  localparam int unsigned DEF_MEM_WIDTH      = 8;
  localparam int unsigned DEF_WORD_SIZE      = 4;
  localparam bit          DEF_CLEAR_ON_RESET = 1'b1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

  // Which register currently drives data_out.
  typedef enum logic [1:0] {
    OUT_ZERO  = 2'd0,
    OUT_ARRAY = 2'd1,
    OUT_FWD   = 2'd2
  } out_sel_e;

endpackage

// File: rtl/ram_array.sv
// Single-write-port, single-synchronous-read-port storage; no reset anywhere.
module ram_array #(
  parameter int MEM_WIDTH = 8,
  parameter int WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [WORD_SIZE-1:0] waddr,
  input  logic [MEM_WIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [WORD_SIZE-1:0] raddr,
  output logic [MEM_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** WORD_SIZE;

  logic [MEM_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register take no reset so they map onto RAM
  // macros; the controller zeroes contents with a sweep and masks rdata instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: post-reset clear sweep, gated user access, write-first
// forwarding on same-address read/write, registered read data with valid.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int MEM_WIDTH      = DEF_MEM_WIDTH,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter bit CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_addr,
  input  logic [MEM_WIDTH-1:0] data_in,
  input  logic                 rd_en,
  input  logic [WORD_SIZE-1:0] rd_addr,
  output logic [MEM_WIDTH-1:0] data_out,
  output logic                 rd_valid,
  output logic                 ready
);

  ram_state_e           state;
  out_sel_e             out_sel;
  logic [WORD_SIZE-1:0] clr_cnt;
  logic [MEM_WIDTH-1:0] fwd_data;
  logic [MEM_WIDTH-1:0] arr_rdata;

  logic                 wr_fire;
  logic                 rd_fire;
  logic                 arr_we;
  logic [WORD_SIZE-1:0] arr_waddr;
  logic [MEM_WIDTH-1:0] arr_wdata;

  assign wr_fire = ready & wr_en;
  assign rd_fire = ready & rd_en;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    arr_we    = wr_fire;
    arr_waddr = wr_addr;
    arr_wdata = data_in;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt;
      arr_wdata = '0;
    end
  end

  ram_array #(
    .MEM_WIDTH(MEM_WIDTH),
    .WORD_SIZE(WORD_SIZE)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (rd_fire),
    .raddr(rd_addr),
    .rdata(arr_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= RUN;
      clr_cnt  <= '0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      out_sel  <= OUT_ZERO;
      fwd_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ready <= 1'b1;
      endcase

      rd_valid <= rd_fire;
      if (rd_fire) begin
        // The array returns pre-write contents, so a colliding write is captured here.
        if (wr_fire && (wr_addr == rd_addr)) begin
          out_sel  <= OUT_FWD;
          fwd_data <= data_in;
        end else begin
          out_sel  <= OUT_ARRAY;
        end
      end
    end
  end

  // Pure select between registers; OUT_ZERO masks the unreset array output.
  always_comb begin
    data_out = '0;
    case (out_sel)
      OUT_ARRAY: data_out = arr_rdata;
      OUT_FWD:   data_out = fwd_data;
      default:   data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: default instance plus a wide no-clear instance.
module tb_ram_ctrl;

  localparam int A_CLR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_wr_en, a_rd_en, a_rv, a_rdy;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic [7:0]  a_din, a_dout;

  logic        b_wr_en, b_rd_en, b_rv, b_rdy;
  logic [5:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_din, b_dout;

  ram_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .data_in(a_din),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .data_out(a_dout), .rd_valid(a_rv), .ready(a_rdy)
  );

  ram_ctrl #(.MEM_WIDTH(16), .WORD_SIZE(6), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .data_in(b_din),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .data_out(b_dout), .rd_valid(b_rv), .ready(b_rdy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  a_mem [16];
  logic [15:0] b_mem [64];
  logic [7:0]  a_q [$];
  logic [15:0] b_q [$];
  int          a_edges = 0;
  int          b_edges = 0;
  bit          a_exp_v = 1'b0;
  bit          b_exp_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: valid must match the model; data is popped only when presented.
  always @(negedge clk) begin
    check("a_rd_valid", 32'(a_rv), 32'(a_exp_v));
    if (a_rv && a_q.size() > 0) check("a_data_out", 32'(a_dout), 32'(a_q.pop_front()));
    else if (a_exp_v && a_q.size() > 0) void'(a_q.pop_front());
    check("b_rd_valid", 32'(b_rv), 32'(b_exp_v));
    if (b_rv && b_q.size() > 0) check("b_data_out", 32'(b_dout), 32'(b_q.pop_front()));
    else if (b_exp_v && b_q.size() > 0) void'(b_q.pop_front());
  end

  task automatic idle();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  // One clock edge: apply the reference model to the pre-edge inputs.
  task automatic tick();
    bit          a_acc, b_acc, a_ok, b_ok;
    logic [7:0]  a_exp;
    logic [15:0] b_exp;
    a_ok  = rst_n && (a_edges >= A_CLR);
    b_ok  = rst_n && (b_edges >= 1);
    a_acc = a_ok && a_rd_en;
    b_acc = b_ok && b_rd_en;
    a_exp = (a_wr_en && a_wr_addr == a_rd_addr) ? a_din : a_mem[a_rd_addr];
    b_exp = (b_wr_en && b_wr_addr == b_rd_addr) ? b_din : b_mem[b_rd_addr];
    if (a_ok && a_wr_en) a_mem[a_wr_addr] = a_din;
    if (b_ok && b_wr_en) b_mem[b_wr_addr] = b_din;
    @(posedge clk);
    #1;
    a_exp_v = a_acc;
    b_exp_v = b_acc;
    if (a_acc) a_q.push_back(a_exp);
    if (b_acc) b_q.push_back(b_exp);
    if (rst_n) begin
      a_edges++;
      b_edges++;
    end
    check("a_ready", 32'(a_rdy), 32'(a_edges >= A_CLR));
    check("b_ready", 32'(b_rdy), 32'(b_edges >= 1));
  endtask

  task automatic assert_reset();
    idle();
    rst_n = 1'b0;
    #1;
    a_exp_v = 1'b0;
    b_exp_v = 1'b0;
    a_q.delete();
    b_q.delete();
    a_edges = 0;
    b_edges = 0;
    foreach (a_mem[i]) a_mem[i] = 8'h00;
    check("a_rst_data_out", 32'(a_dout), 32'h0);
    check("a_rst_rd_valid", 32'(a_rv), 32'h0);
    check("a_rst_ready", 32'(a_rdy), 32'h0);
    check("b_rst_data_out", 32'(b_dout), 32'h0);
    check("b_rst_rd_valid", 32'(b_rv), 32'h0);
    check("b_rst_ready", 32'(b_rdy), 32'h0);
    @(posedge clk);
    #1;
    check("a_rst_hold_ready", 32'(a_rdy), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    a_wr_addr = '0; a_rd_addr = '0; a_din = '0;
    b_wr_addr = '0; b_rd_addr = '0; b_din = '0;
    #3;
    @(posedge clk);
    #1;
    assert_reset();

    // Clear sweep, then read every location back-to-back.
    repeat (A_CLR) tick();
    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 4'(i);
      tick();
    end
    idle(); tick();

    // Write then read next cycle.
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_din = 8'hA5; tick();
    a_wr_en = 1'b0; a_rd_en = 1'b1; a_rd_addr = 4'd3; tick();
    idle(); tick(); tick();

    // Same-edge write and read to one address.
    a_wr_en = 1'b1; a_wr_addr = 4'd7; a_din = 8'h3C;
    a_rd_en = 1'b1; a_rd_addr = 4'd7; tick();
    idle(); tick(); tick();

    // Random traffic with frequent address collisions.
    repeat (300) begin
      a_wr_en   = 1'($urandom_range(0, 1));
      a_rd_en   = 1'($urandom_range(0, 1));
      a_wr_addr = 4'($urandom);
      a_din     = 8'($urandom);
      a_rd_addr = ($urandom_range(0, 3) == 0) ? a_wr_addr : 4'($urandom);
      tick();
    end
    idle(); tick(); tick();

    // Reset during RUN, then again at clear count 9.
    assert_reset();
    repeat (9) tick();
    assert_reset();

    // Requests while not ready must be ignored.
    a_wr_en = 1'b1; a_wr_addr = 4'd2; a_din = 8'hFF;
    a_rd_en = 1'b1; a_rd_addr = 4'd2;
    repeat (A_CLR) tick();
    idle();
    a_rd_en = 1'b1; a_rd_addr = 4'd2; tick();
    idle(); tick(); tick();

    // Wide instance without clear.
    b_wr_en = 1'b1; b_wr_addr = 6'd63; b_din = 16'hBEEF; tick();
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_addr = 6'd63; tick();
    idle(); tick();
    for (int i = 0; i < 64; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 6'(i); b_din = 16'($urandom);
      tick();
    end
    repeat (200) begin
      b_wr_en   = 1'($urandom_range(0, 1));
      b_rd_en   = 1'($urandom_range(0, 1));
      b_wr_addr = 6'($urandom);
      b_din     = 16'($urandom);
      b_rd_addr = ($urandom_range(0, 3) == 0) ? b_wr_addr : 6'($urandom);
      tick();
    end
    idle(); tick(); tick();

    check("a_queue_drained", 32'(a_q.size()), 32'h0);
    check("b_queue_drained", 32'(b_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter MEM_WIDTH, default 8, data word width in bits.
REQ-002 Parameter WORD_SIZE, default 4, address width in bits; depth = 2**WORD_SIZE.
REQ-003 Parameter CLEAR_ON_RESET, default 1; 1 = zero every location after reset, 0 = skip clear.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_addr  input  WORD_SIZE  write address.
REQ-008 data_in  input  MEM_WIDTH  write data.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_addr  input  WORD_SIZE  read address.
REQ-011 data_out  output  MEM_WIDTH  registered read data.
REQ-012 rd_valid  output  1  data_out holds the result of a read accepted on the previous edge.
REQ-013 ready  output  1  controller accepts requests.

Function
REQ-014 FSM states: CLEAR, RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-015 CLEAR: internal counter starts at 0, writes 0 to location counter each cycle, increments by 1.
REQ-016 CLEAR -> RUN on the edge that writes location 2**WORD_SIZE-1; clear takes exactly 2**WORD_SIZE cycles.
REQ-017 ready = 1 only in RUN; registered, so it rises on the edge the FSM enters RUN.
REQ-018 wr_en and rd_en are ignored while ready=0; no write, rd_valid stays 0.
REQ-019 Write: wr_en=1 and ready=1 at an edge stores data_in at wr_addr at that edge.
REQ-020 Read: rd_en=1 and ready=1 at an edge loads data_out with mem[rd_addr] and sets rd_valid=1; latency 1 cycle.
REQ-021 rd_valid drops to 0 on any edge without an accepted read; data_out holds its last value.
REQ-022 Same-edge read and write to the same address: data_out returns data_in (write-first forwarding).
REQ-023 Same-edge read and write to different addresses: both complete independently.
REQ-024 Addresses wrap naturally within WORD_SIZE bits; no out-of-range condition exists.
REQ-025 Back-to-back reads every cycle are supported; rd_valid stays 1 throughout.

Reset
REQ-026 Asserting rst_n=0 immediately forces data_out=0, rd_valid=0, ready=0, clear counter=0.
REQ-027 Reset mid-CLEAR or mid-RUN aborts in-flight operations; clear restarts from address 0 after release.
REQ-028 Memory array is not reset directly; contents are defined only after CLEAR completes (CLEAR_ON_RESET=1).
REQ-029 With CLEAR_ON_RESET=0, ready rises on the first edge after rst_n release; contents undefined until written.

Structure
REQ-030 Package ram_pkg holds the FSM state type (CLEAR, RUN) and default parameter constants.
REQ-031 Storage lives in one sub-module ram_array (single write port, single synchronous read port, no reset); ram_ctrl holds FSM, muxing of clear vs user write, and forwarding.
REQ-032 Write port of ram_array is driven by the clear counter in CLEAR and by wr_* in RUN.

Verification
REQ-033 Defaults, release rst_n -> ready=0 for exactly 16 cycles, then 1; reads of addresses 0..15 all return 0x00.
REQ-034 Write 0xA5 to 3, next cycle read 3 -> one cycle later data_out=0xA5, rd_valid=1, then rd_valid=0.
REQ-035 Same edge: wr_en addr 7 data 0x3C, rd_en addr 7 -> next cycle data_out=0x3C.
REQ-036 Pulse rst_n=0 at clear count 9 -> outputs 0 immediately; after release ready rises after 16 full cycles.
REQ-037 wr_en addr 2 data 0xFF while ready=0, then read 2 after ready -> 0x00, rd_valid 1 only for the post-ready read.
REQ-038 CLEAR_ON_RESET=0, MEM_WIDTH=16, WORD_SIZE=6 -> ready 1 edge after release; write/read 0xBEEF at 63 returns 0xBEEF.
